// File: rtl/mult256_stream_seq.sv
// Stream sequencer for mult256: loads A/B from beats, waits, streams product out.
// Optional frame checking (in_last / frame_err) under MULT256_STREAM_SEQ_FRAME_CHK_EN.
module mult256_stream_seq #(
  parameter int BUS_W    = 32,
  parameter int OP_W     = 256,
  parameter int MULT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BUS_W-1:0]  in_data,
`ifdef MULT256_STREAM_SEQ_FRAME_CHK_EN
  input  logic              in_last,
  output logic              frame_err,
`endif
  output logic [OP_W-1:0]   mult_a,
  output logic [OP_W-1:0]   mult_b,
  input  logic [2*OP_W-1:0] mult_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUS_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int N  = OP_W / BUS_W;
  localparam int NB = 2 * N;
  localparam int KW = (NB > 2) ? $clog2(NB) : 1;
  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   j;
  logic [KW-1:0]   jn;
  logic [CW-1:0]   cnt;
  logic [2*OP_W-1:0] res;
  logic            k_last;
  logic            bad_beat;

  always_comb begin
    jn     = j + 1'b1;
    k_last = (k == KW'(NB - 1));
`ifdef MULT256_STREAM_SEQ_FRAME_CHK_EN
    bad_beat = (in_last != k_last);
`else
    bad_beat = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      k         <= '0;
      j         <= '0;
      cnt       <= '0;
      res       <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
`ifdef MULT256_STREAM_SEQ_FRAME_CHK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (bad_beat) begin
              // Drop the partial frame; resync on the next beat as A word 0
              k <= '0;
`ifdef MULT256_STREAM_SEQ_FRAME_CHK_EN
              frame_err <= 1'b1;
`endif
            end else begin
              if (k < KW'(N))
                mult_a[BUS_W*k +: BUS_W] <= in_data;
              else
                mult_b[BUS_W*(k-KW'(N)) +: BUS_W] <= in_data;
              if (k_last) begin
                state    <= WAIT;
                k        <= '0;
                cnt      <= CW'(MULT_LAT - 1);
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end else begin
                k <= k + 1'b1;
              end
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            res   <= mult_result;
            state <= SEND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SEND: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= res[BUS_W*j +: BUS_W];
            out_last  <= (j == KW'(NB - 1));
          end else if (out_ready) begin
            if (out_last) begin
              state     <= LOAD;
              j         <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              j        <= jn;
              out_data <= res[BUS_W*jn +: BUS_W];
              out_last <= (jn == KW'(NB - 1));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mult256_stream_seq.sv
// Directed bench for mult256_stream_seq with a behavioural multiplier.
// Frame-check cases run only with MULT256_STREAM_SEQ_FRAME_CHK_EN defined.
module tb_mult256_stream_seq;

  localparam int BUS_W = 32;
  localparam int OP_W  = 256;
  localparam int N     = 8;
  localparam int NB    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             frame_err;
  logic [255:0]     mult_a;
  logic [255:0]     mult_b;
  logic [511:0]     mult_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             busy;

  always #5 clk = ~clk;

  assign mult_result = {256'b0, mult_a} * {256'b0, mult_b};

  mult256_stream_seq #(
    .BUS_W(BUS_W), .OP_W(OP_W), .MULT_LAT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef MULT256_STREAM_SEQ_FRAME_CHK_EN
    .in_last(in_last),
    .frame_err(frame_err),
`endif
    .mult_a(mult_a),
    .mult_b(mult_b),
    .mult_result(mult_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
  );

`ifndef MULT256_STREAM_SEQ_FRAME_CHK_EN
  assign frame_err = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] p;
    int           gap;
    int           stall_beat;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [255:0] a, input logic [255:0] b,
                            input int gap, input int err_beat, input int nb);
    for (int k = 0; k < nb; k++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        total++;
        bad++;
        $display("FAIL in_ready_timeout: beat %0d never accepted", k);
      end
      in_valid = 1'b1;
      in_data  = (k < N) ? a[32*k +: 32] : b[32*(k-N) +: 32];
      in_last  = (err_beat >= 0) ? (k == err_beat) : (k == NB - 1);
      @(posedge clk);
      #1;
      if (gap > 0 && k != nb - 1) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    in_last = 1'b0;
  endtask

  task automatic recv_frame(input logic [511:0] p, input int stall_beat,
                            input int stall_n, input string tag);
    for (int j = 0; j < NB; j++) begin
      int w;
      logic [31:0] ew;
      logic        el;
      w  = 0;
      ew = p[32*j +: 32];
      el = (j == NB - 1);
      @(negedge clk);
      while (!out_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!out_valid) begin
        total++;
        bad++;
        $display("FAIL %s_out_timeout: beat %0d got no out_valid want 1", tag, j);
        return;
      end
      if (j == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check($sformatf("%s_hold%0d", tag, s),
                {out_valid, out_last, out_data}, {1'b1, el, ew});
        end
        out_ready = 1'b1;
      end
      check($sformatf("%s_beat%0d", tag, j), {out_last, out_data}, {el, ew});
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, "_drop"}, {out_valid, out_last}, 2'b00);
  endtask

  initial begin
    int n;
    tbl[0] = '{256'd1, 256'd1, 512'd1, 0, -1};
    tbl[1] = '{{256{1'b1}}, {256{1'b1}},
               {{7{32'hFFFFFFFF}}, 32'hFFFFFFFE, {7{32'h0}}, 32'h1}, 0, 3};
    tbl[2] = '{256'd3, 256'd5, 512'd15, 2, -1};
    tbl[3] = '{{1'b1, 255'b0}, 256'd2, {255'b0, 1'b1, 256'b0}, 0, -1};
    tbl[4] = '{256'hFFFFFFFF, 256'hFFFFFFFF, 512'hFFFFFFFE_00000001, 1, 0};
    tbl[5] = '{256'h1_0000_0000_0000_0000,
               256'h1_0000_0000_0000_0000_0000_0000,
               {351'b0, 1'b1, 160'b0}, 0, -1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_ctrl", {in_ready, out_valid, out_last, busy, frame_err},
          5'b10000);
    check("rst_data", {out_data, mult_a, mult_b}, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].a, tbl[i].b, tbl[i].gap, -1, NB);
      if (i == 0) begin
        // Junk offered during WAIT/SEND must be ignored
        in_data = 32'hDEADBEEF;
        check("lat_ready_low", {in_ready, busy}, 2'b01);
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("lat_edges", n, 3);
        check("lat_busy", busy, 1'b1);
      end
      in_valid = 1'b0;
      check($sformatf("v%0d_ops", i), {mult_a, mult_b}, {tbl[i].a, tbl[i].b});
      recv_frame(tbl[i].p, tbl[i].stall_beat, 5, $sformatf("v%0d", i));
      check($sformatf("v%0d_idle", i), {in_ready, busy}, 2'b10);
    end

    send_frame({8{32'hA5A5A5A5}}, {8{32'h5A5A5A5A}}, 0, -1, 5);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ops", {mult_a, mult_b}, '0);
    check("mid_rst_ctrl", {in_ready, out_valid, busy}, 3'b100);
    #2;
    reset = 1'b0;
    send_frame(256'd3, 256'd5, 0, -1, NB);
    in_valid = 1'b0;
    recv_frame(512'd15, -1, 0, "rst35");

`ifdef MULT256_STREAM_SEQ_FRAME_CHK_EN
    check("ferr_clear", frame_err, 1'b0);
    send_frame({8{32'h11111111}}, {8{32'h22222222}}, 0, 6, 7);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("ferr_set", {frame_err, out_valid, in_ready, busy}, 4'b1010);
    send_frame(256'd2, 256'd7, 0, -1, NB);
    in_valid = 1'b0;
    recv_frame(512'd14, -1, 0, "ferr27");
    check("ferr_sticky", frame_err, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
